waveform_playback: RTL and testbench

Playback counterpart of the triggered capture buffer: the host loads a waveform frame into a double-banked dual-port RAM, commits it, and on a trigger the block streams the frame out one sample per output strobe, once or looping. It sits between the host register/DMA write path and a DAC-side sample consumer, on a single clock. It reports completed frames and missed triggers in the same 16-bit status format as the capture side.

---
 rtl/waveform_playback_pkg.sv | 22 ++
 rtl/waveform_playback_dpram.sv | 49 ++++
 rtl/waveform_playback.sv | 178 +++++++++++++++++
 tb/tb_waveform_playback.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/waveform_playback_pkg.sv
// ----------------------------------------------------------------------------
// waveform_playback_pkg
//   Shared definitions for the waveform playback block: the 2-bit player state
//   encoding, the width of the frame-complete / missed-trigger status counters,
//   and a saturating increment used by the missed-trigger counter.
// ----------------------------------------------------------------------------
package waveform_playback_pkg;

    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        PLAY  = 2'd2
    } state_t;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        return (&value) ? value : value + STAT_W'(1);
    endfunction

endpackage

// File: rtl/waveform_playback_dpram.sv
// ----------------------------------------------------------------------------
// dpram
//   Simple dual-port RAM, single clock. Port a is write-only, port b is
//   read-only with a registered output (one cycle read latency). The output
//   register holds its value when no read is issued.
//
// Ports:
//   clk     in   sole clock
//   reset   in   asynchronous, active-high; clears only the read register
//   stb_a   in   write enable, port a
//   addr_a  in   write address
//   data_a  in   write data
//   stb_b   in   read enable, port b
//   addr_b  in   read address
//   data_b  out  registered read data
// ----------------------------------------------------------------------------
module dpram #(
    parameter int aw = 14,
    parameter int dw = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stb_a,
    input  logic [aw-1:0] addr_a,
    input  logic [dw-1:0] data_a,
    input  logic          stb_b,
    input  logic [aw-1:0] addr_b,
    output logic [dw-1:0] data_b
);

    logic [dw-1:0] mem [0:(1<<aw)-1];

    // NOTE: the array has no reset so it maps onto block RAM; only the
    // output register below is reset.
    always_ff @(posedge clk) begin
        if (stb_a) begin
            mem[addr_a] <= data_a;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_b <= '0;
        end else if (stb_b) begin
            data_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/waveform_playback.sv
// ----------------------------------------------------------------------------
// waveform_playback
//   Double-banked waveform player. The host fills the write bank and commits
//   it; the committed bank is swapped in for the player, which on a trigger
//   streams the frame out one sample per stb_r. Frames completed and triggers
//   missed are reported as 16-bit counters.
//
//   Optional feature macro: PLAYBACK_LOOP_EN. When defined, the loop input is
//   honoured at each end-of-frame; when undefined every frame is one-shot.
//
// Ports:
//   clk            in   sole clock
//   reset          in   asynchronous, active-high
//   stb_w          in   host write strobe
//   addr_w         in   host write address within the write bank
//   data_w         in   host write data
//   commit         in   pulse: write bank holds a complete frame
//   len_w          in   frame length minus 1, sampled on commit
//   trig_ext       in   external trigger level
//   trig_internal  in   1 = self-trigger whenever ARMED
//   loop           in   1 = replay frame continuously (PLAYBACK_LOOP_EN only)
//   stb_r          in   output sample-rate strobe
//   data_r         out  output sample
//   data_gate      out  data_r valid this cycle
//   trig_out       out  first sample of a frame, aligned with data_gate
//   busy           out  player is in PLAY
//   buf_count      out  frames completed, wraps
//   buf_stat       out  triggers missed, saturates
// ----------------------------------------------------------------------------
module waveform_playback
    import waveform_playback_pkg::*;
#(
    parameter int aw = 13,
    parameter int dw = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stb_w,
    input  logic [aw-1:0]     addr_w,
    input  logic [dw-1:0]     data_w,
    input  logic              commit,
    input  logic [aw-1:0]     len_w,
    input  logic              trig_ext,
    input  logic              trig_internal,
    input  logic              loop,
    input  logic              stb_r,
    output logic [dw-1:0]     data_r,
    output logic              data_gate,
    output logic              trig_out,
    output logic              busy,
    output logic [STAT_W-1:0] buf_count,
    output logic [STAT_W-1:0] buf_stat
);

    state_t        state;
    logic          w_bank;
    logic          pending;
    logic          valid;
    logic [aw-1:0] r_addr;
    logic [aw-1:0] r_len;
    logic [aw-1:0] len_pend;

    logic          trig;
    logic          rd_en;
    logic          eof;
    logic          swap;
    logic [aw-1:0] swap_len;
    logic          loop_act;

`ifdef PLAYBACK_LOOP_EN
    assign loop_act = loop;
`else
    assign loop_act = 1'b0;
    logic unused_loop;
    assign unused_loop = loop;
`endif

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        trig     = trig_internal | trig_ext;
        rd_en    = (state == PLAY) && stb_r;
        // Compare before incrementing, so r_len = all-ones plays the full bank.
        eof      = rd_en && (r_addr == r_len);
        swap     = pending && ((state != PLAY) || eof);
        // A commit landing in the swap cycle overrides the older pending length.
        swap_len = commit ? len_w : len_pend;
    end

    assign busy = (state == PLAY);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here sees the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            w_bank    <= 1'b0;
            pending   <= 1'b0;
            valid     <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
            len_pend  <= '0;
            data_gate <= 1'b0;
            trig_out  <= 1'b0;
            buf_count <= '0;
            buf_stat  <= '0;
        end else begin
            data_gate <= rd_en;
            trig_out  <= rd_en && (r_addr == '0);

            if (commit) begin
                len_pend <= len_w;
            end

            if (swap) begin
                w_bank  <= ~w_bank;
                r_len   <= swap_len;
                pending <= 1'b0;
                valid   <= 1'b1;
            end else if (commit) begin
                pending <= 1'b1;
            end

            if (eof) begin
                buf_count <= buf_count + STAT_W'(1);
            end

            // Triggers are only consumed while ARMED; anywhere else they are lost.
            if (trig && (state != ARMED)) begin
                buf_stat <= sat_inc(buf_stat);
            end

            case (state)
                IDLE: begin
                    if (swap) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (trig && valid) begin
                        state  <= PLAY;
                        r_addr <= '0;
                    end
                end
                PLAY: begin
                    if (stb_r) begin
                        if (r_addr == r_len) begin
                            if (loop_act) begin
                                r_addr <= '0;
                            end else begin
                                state <= ARMED;
                            end
                        end else begin
                            r_addr <= r_addr + aw'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bank select is the address MSB: host writes w_bank, player reads the other.
    dpram #(
        .aw (aw + 1),
        .dw (dw)
    ) u_dpram (
        .clk    (clk),
        .reset  (reset),
        .stb_a  (stb_w),
        .addr_a ({w_bank, addr_w}),
        .data_a (data_w),
        .stb_b  (rd_en),
        .addr_b ({~w_bank, r_addr}),
        .data_b (data_r)
    );

endmodule

// File: tb/tb_waveform_playback.sv
// ----------------------------------------------------------------------------
// tb_waveform_playback
//   Directed testbench for waveform_playback: reset state, single-frame play,
//   missed triggers, commit during play, looping (or one-shot without
//   PLAYBACK_LOOP_EN), full-bank frame, and reset mid-play.
// ----------------------------------------------------------------------------
module tb_waveform_playback;
    import waveform_playback_pkg::*;

    localparam int AW = 13;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          stb_w;
    logic [AW-1:0] addr_w;
    logic [DW-1:0] data_w;
    logic          commit;
    logic [AW-1:0] len_w;
    logic          trig_ext;
    logic          trig_internal;
    logic          loop;
    logic          stb_r;
    logic [DW-1:0] data_r;
    logic          data_gate;
    logic          trig_out;
    logic          busy;
    logic [15:0]   buf_count;
    logic [15:0]   buf_stat;

    int checks   = 0;
    int failures = 0;
    int exp_count;

    logic [DW-1:0] got_d[$];
    logic          got_t[$];

    waveform_playback #(.aw(AW), .dw(DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .stb_w         (stb_w),
        .addr_w        (addr_w),
        .data_w        (data_w),
        .commit        (commit),
        .len_w         (len_w),
        .trig_ext      (trig_ext),
        .trig_internal (trig_internal),
        .loop          (loop),
        .stb_r         (stb_r),
        .data_r        (data_r),
        .data_gate     (data_gate),
        .trig_out      (trig_out),
        .busy          (busy),
        .buf_count     (buf_count),
        .buf_stat      (buf_stat)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_sample(input int a, input logic [DW-1:0] d);
        stb_w  = 1'b1;
        addr_w = AW'(a);
        data_w = d;
        tick();
        stb_w  = 1'b0;
    endtask

    task automatic commit_frame(input int len);
        commit = 1'b1;
        len_w  = AW'(len);
        tick();
        commit = 1'b0;
    endtask

    task automatic pulse_trig();
        trig_ext = 1'b1;
        tick();
        trig_ext = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Strobe every 'period' cycles for 'ncyc' cycles, raising trig_ext at
    // cycles t1/t2 (-1 = none), and collect every gated sample.
    task automatic play(input int ncyc, input int period, input int t1, input int t2);
        got_d.delete();
        got_t.delete();
        for (int c = 0; c < ncyc; c++) begin
            stb_r    = (c % period == 0);
            trig_ext = (c == t1) || (c == t2);
            tick();
            if (data_gate) begin
                got_d.push_back(data_r);
                got_t.push_back(trig_out);
            end
        end
        stb_r    = 1'b0;
        trig_ext = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; stb_w = 0; addr_w = '0; data_w = '0; commit = 0; len_w = '0;
        trig_ext = 0; trig_internal = 0; loop = 0; stb_r = 0;
        tick();
        tick();
        checks++; if (data_r !== '0) begin failures++; $display("FAIL reset_data_r: got %h expected 0", data_r); end
        checks++; if (data_gate !== 1'b0) begin failures++; $display("FAIL reset_data_gate: got %b expected 0", data_gate); end
        checks++; if (trig_out !== 1'b0) begin failures++; $display("FAIL reset_trig_out: got %b expected 0", trig_out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (buf_count !== 16'h0) begin failures++; $display("FAIL reset_buf_count: got %h expected 0", buf_count); end
        checks++; if (buf_stat !== 16'h0) begin failures++; $display("FAIL reset_buf_stat: got %h expected 0", buf_stat); end
        checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d expected 0", dut.state); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        for (int i = 0; i < 4; i++) write_sample(i, DW'(16'h10 + i));
        commit_frame(3);
        tick();
        checks++; if (dut.state !== ARMED) begin failures++; $display("FAIL single_armed: got %0d expected 1", dut.state); end
        pulse_trig();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b expected 1", busy); end
        play(15, 3, -1, -1);
        checks++; if (got_d.size() != 4) begin failures++; $display("FAIL single_count: got %0d samples expected 4", got_d.size()); end
        for (int i = 0; i < 4 && i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== DW'(16'h10 + i)) begin failures++; $display("FAIL single_data[%0d]: got %h expected %h", i, got_d[i], 16'h10 + i); end
            checks++; if (got_t[i] !== (i == 0)) begin failures++; $display("FAIL single_trig_out[%0d]: got %b expected %b", i, got_t[i], i == 0); end
        end
        checks++; if (buf_count !== 16'd1) begin failures++; $display("FAIL single_buf_count: got %0d expected 1", buf_count); end
        checks++; if (dut.state !== ARMED) begin failures++; $display("FAIL single_end_state: got %0d expected 1", dut.state); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_end_busy: got %b expected 0", busy); end
        checks++; if (data_r !== 16'h0013) begin failures++; $display("FAIL single_data_hold: got %h expected 0013", data_r); end
    endtask

    task automatic test_missed_triggers();
        apply_reset();
        pulse_trig();
        checks++; if (buf_stat !== 16'd1) begin failures++; $display("FAIL miss_idle: got %0d expected 1", buf_stat); end
        commit_frame(3);
        tick();
        pulse_trig();
        play(15, 3, 1, 4);
        checks++; if (buf_stat !== 16'd3) begin failures++; $display("FAIL miss_play: got %0d expected 3", buf_stat); end
        checks++; if (got_d.size() != 4) begin failures++; $display("FAIL miss_count: got %0d samples expected 4", got_d.size()); end
        for (int i = 0; i < 4 && i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== DW'(16'h10 + i)) begin failures++; $display("FAIL miss_data[%0d]: got %h expected %h", i, got_d[i], 16'h10 + i); end
        end
        checks++; if (buf_count !== 16'd1) begin failures++; $display("FAIL miss_buf_count: got %0d expected 1", buf_count); end
    endtask

    task automatic test_commit_during_play();
        pulse_trig();
        got_d.delete();
        got_t.delete();
        for (int c = 0; c < 15; c++) begin
            stb_r  = (c % 3 == 0);
            stb_w  = (c < 2);
            addr_w = AW'(c);
            data_w = DW'(16'hB0 + c);
            commit = (c == 2);
            len_w  = AW'(1);
            tick();
            if (data_gate) begin
                got_d.push_back(data_r);
                got_t.push_back(trig_out);
            end
        end
        stb_r = 0; stb_w = 0; commit = 0;
        checks++; if (got_d.size() != 4) begin failures++; $display("FAIL cdp_a_count: got %0d samples expected 4", got_d.size()); end
        for (int i = 0; i < 4 && i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== DW'(16'h10 + i)) begin failures++; $display("FAIL cdp_a_data[%0d]: got %h expected %h", i, got_d[i], 16'h10 + i); end
        end
        checks++; if (buf_count !== 16'd2) begin failures++; $display("FAIL cdp_a_buf_count: got %0d expected 2", buf_count); end
        // A strobe coincident with the trigger must not fetch a sample.
        trig_ext = 1'b1;
        stb_r    = 1'b1;
        tick();
        trig_ext = 1'b0;
        stb_r    = 1'b0;
        checks++; if (data_gate !== 1'b0) begin failures++; $display("FAIL cdp_trig_cycle_gate: got %b expected 0", data_gate); end
        play(9, 3, -1, -1);
        checks++; if (got_d.size() != 2) begin failures++; $display("FAIL cdp_b_count: got %0d samples expected 2", got_d.size()); end
        for (int i = 0; i < 2 && i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== DW'(16'hB0 + i)) begin failures++; $display("FAIL cdp_b_data[%0d]: got %h expected %h", i, got_d[i], 16'hB0 + i); end
            checks++; if (got_t[i] !== (i == 0)) begin failures++; $display("FAIL cdp_b_trig_out[%0d]: got %b expected %b", i, got_t[i], i == 0); end
        end
        checks++; if (buf_count !== 16'd3) begin failures++; $display("FAIL cdp_b_buf_count: got %0d expected 3", buf_count); end
        checks++; if (dut.state !== ARMED) begin failures++; $display("FAIL cdp_b_state: got %0d expected 1", dut.state); end
    endtask

    task automatic test_loop();
        for (int i = 0; i < 3; i++) write_sample(i, DW'(16'h40 + i));
        commit_frame(2);
        tick();
        loop = 1'b1;
        pulse_trig();
        play(10, 1, -1, -1);
`ifdef PLAYBACK_LOOP_EN
        checks++; if (got_d.size() != 10) begin failures++; $display("FAIL loop_count: got %0d samples expected 10", got_d.size()); end
        for (int i = 0; i < 10 && i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== DW'(16'h40 + i % 3)) begin failures++; $display("FAIL loop_data[%0d]: got %h expected %h", i, got_d[i], 16'h40 + i % 3); end
            checks++; if (got_t[i] !== (i % 3 == 0)) begin failures++; $display("FAIL loop_trig_out[%0d]: got %b expected %b", i, got_t[i], i % 3 == 0); end
        end
        checks++; if (buf_count !== 16'd6) begin failures++; $display("FAIL loop_buf_count: got %0d expected 6", buf_count); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL loop_busy: got %b expected 1", busy); end
        loop = 1'b0;
        play(4, 1, -1, -1);
        checks++; if (got_d.size() != 2) begin failures++; $display("FAIL loop_tail_count: got %0d samples expected 2", got_d.size()); end
        exp_count = 7;
`else
        checks++; if (got_d.size() != 3) begin failures++; $display("FAIL oneshot_count: got %0d samples expected 3", got_d.size()); end
        for (int i = 0; i < 3 && i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== DW'(16'h40 + i)) begin failures++; $display("FAIL oneshot_data[%0d]: got %h expected %h", i, got_d[i], 16'h40 + i); end
        end
        exp_count = 4;
`endif
        loop = 1'b0;
        checks++; if (buf_count !== 16'(exp_count)) begin failures++; $display("FAIL loop_end_buf_count: got %0d expected %0d", buf_count, exp_count); end
        checks++; if (dut.state !== ARMED) begin failures++; $display("FAIL loop_end_state: got %0d expected 1", dut.state); end
    endtask

    task automatic test_full_bank();
        int bad_data;
        int bad_trig;
        int first_bad;
        for (int i = 0; i < (1 << AW); i++) write_sample(i, DW'(i) ^ 16'hC3A5);
        commit_frame((1 << AW) - 1);
        tick();
        pulse_trig();
        play((1 << AW) + 4, 1, -1, -1);
        checks++; if (got_d.size() != (1 << AW)) begin failures++; $display("FAIL full_count: got %0d samples expected %0d", got_d.size(), 1 << AW); end
        bad_data = 0; bad_trig = 0; first_bad = -1;
        for (int i = 0; i < (1 << AW) && i < got_d.size(); i++) begin
            if (got_d[i] !== (DW'(i) ^ 16'hC3A5)) begin
                bad_data++;
                if (first_bad < 0) first_bad = i;
            end
            if (got_t[i] !== (i == 0)) bad_trig++;
        end
        checks++; if (bad_data != 0) begin failures++; $display("FAIL full_data: got %0d wrong samples (first at %0d) expected 0", bad_data, first_bad); end
        checks++; if (bad_trig != 0) begin failures++; $display("FAIL full_trig_out: got %0d wrong flags expected 0", bad_trig); end
        exp_count++;
        checks++; if (buf_count !== 16'(exp_count)) begin failures++; $display("FAIL full_buf_count: got %0d expected %0d", buf_count, exp_count); end
        checks++; if (dut.state !== ARMED) begin failures++; $display("FAIL full_state: got %0d expected 1", dut.state); end
    endtask

    task automatic test_reset_mid_play();
        pulse_trig();
        stb_r = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (data_gate !== 1'b1) begin failures++; $display("FAIL midrst_pre_gate: got %b expected 1", data_gate); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (data_r !== '0) begin failures++; $display("FAIL midrst_data_r: got %h expected 0", data_r); end
        checks++; if (data_gate !== 1'b0) begin failures++; $display("FAIL midrst_data_gate: got %b expected 0", data_gate); end
        checks++; if (trig_out !== 1'b0) begin failures++; $display("FAIL midrst_trig_out: got %b expected 0", trig_out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (buf_count !== 16'h0) begin failures++; $display("FAIL midrst_buf_count: got %0d expected 0", buf_count); end
        checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL midrst_state: got %0d expected 0", dut.state); end
        stb_r = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        pulse_trig();
        checks++; if (buf_stat !== 16'd1) begin failures++; $display("FAIL midrst_buf_stat: got %0d expected 1", buf_stat); end
        checks++; if (buf_count !== 16'h0) begin failures++; $display("FAIL midrst_no_partial: got %0d expected 0", buf_count); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_missed_triggers();
        test_commit_during_play();
        test_loop();
        test_full_bank();
        test_reset_mid_play();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
